// File: rtl/mul_arbiter.sv
// Two-requester arbiter sharing one combinational 8x8 multiplier (low 8 bits of product).
// Optional `MUL_ARB_RR_EN selects round-robin tie-breaking; fixed priority (req0) otherwise.

module eight_bit_multiplier_module (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;

  // Shift-add of partial products; only bits that reach the low byte are kept.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      acc = acc + ({8{b[i]}} & (a << i));
    end
  end

  assign p = acc;

endmodule

module mul_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] result,
  output logic       busy
);

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [7:0] result_q, result_d;
  logic       last_gnt_q, last_gnt_d;
  logic       win;
  logic [7:0] mul_p;

  eight_bit_multiplier_module u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // win is only meaningful when at least one request is present.
  always_comb begin
`ifdef MUL_ARB_RR_EN
    if (req0 && req1) begin
      win = ~last_gnt_q;
    end else begin
      win = req1;
    end
`else
    win = ~req0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    result_d   = result_q;
    last_gnt_d = last_gnt_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (req0 || req1) begin
          op_a_d     = win ? a1 : a0;
          op_b_d     = win ? b1 : b0;
          gnt_d      = win ? 2'b10 : 2'b01;
          last_gnt_d = win;
          cnt_d      = CNT_INIT;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == '0) begin
          result_d = mul_p;
          done_d   = gnt_q;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: vector table, corner sequences and randomized traffic
// checked against a transaction-level model of arbitration, latency and truncated product.

module tb_mul_arbiter;

  localparam int unsigned W = 2;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] gnt, done;
  logic [7:0] result;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int last_k = 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         sel;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  mul_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int arb(input logic r0, input logic r1, input int last);
    if (r0 && r1) begin
`ifdef MUL_ARB_RR_EN
      return (last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  function automatic logic [7:0] prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return 8'(p % 256);
  endfunction

  // Called in an IDLE cycle with requests already applied; follows one full transaction.
  // mid: 0 none, 1 scramble winner operands during CALC, 2 raise req1 during CALC.
  task automatic serve(input int mid, input bit drop, output int k);
    logic [1:0] oh;
    logic [7:0] exp_res;
    k = arb(req0, req1, last_k);
    oh = (k == 0) ? 2'b01 : 2'b10;
    exp_res = (k == 0) ? prod(a0, b0) : prod(a1, b1);
    for (int c = 1; c <= int'(W) + 1; c++) begin
      tick;
      chk("calc_gnt", 16'(gnt), 16'(oh));
      chk("calc_done", 16'(done), 16'd0);
      chk("calc_busy", 16'(busy), 16'd1);
      if (c == 1 && mid == 1) begin
        if (k == 0) begin a0 = 8'd0; b0 = 8'(~b0); end
        else        begin a1 = 8'd0; b1 = 8'(~b1); end
      end
      if (c == 1 && mid == 2) req1 = 1'b1;
    end
    tick;
    chk("resp_done", 16'(done), 16'(oh));
    chk("resp_gnt", 16'(gnt), 16'(oh));
    chk("resp_busy", 16'(busy), 16'd1);
    chk("resp_result", 16'(result), 16'(exp_res));
    last_k = k;
    if (drop) begin
      if (k == 0) req0 = 1'b0;
      else        req1 = 1'b0;
    end
    tick;
    chk("idle_gnt", 16'(gnt), 16'd0);
    chk("idle_done", 16'(done), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_result_hold", 16'(result), 16'(exp_res));
  endtask

  initial begin
    int k;
    int exp_seq[3];
    bit drop;

    tbl[0] = '{8'd1,   8'd2,   0, 8'h02};
    tbl[1] = '{8'd4,   8'd16,  1, 8'h40};
    tbl[2] = '{8'd64,  8'd12,  0, 8'h00};
    tbl[3] = '{8'd9,   8'd112, 0, 8'hF0};
    tbl[4] = '{8'd255, 8'd255, 1, 8'h01};
    tbl[5] = '{8'd0,   8'd200, 0, 8'h00};
    tbl[6] = '{8'd15,  8'd17,  1, 8'hFF};
    tbl[7] = '{8'd16,  8'd16,  0, 8'h00};
    tbl[8] = '{8'd13,  8'd11,  1, 8'h8F};
    tbl[9] = '{8'd128, 8'd3,   0, 8'h80};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick;
    tick;
    chk("rst_gnt", 16'(gnt), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", 16'(result), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    tick;

    foreach (tbl[i]) begin
      if (tbl[i].sel == 0) begin a0 = tbl[i].a; b0 = tbl[i].b; req0 = 1'b1; end
      else                 begin a1 = tbl[i].a; b1 = tbl[i].b; req1 = 1'b1; end
      serve(0, 1'b1, k);
      chk("tbl_winner", 16'(k), 16'(tbl[i].sel));
      chk("tbl_result", 16'(result), 16'(tbl[i].exp));
    end

    // Operands scrambled after the grant must not affect the product.
    a1 = 8'd4; b1 = 8'd16; req1 = 1'b1;
    serve(1, 1'b1, k);
    chk("latched_ops", 16'(result), 16'h40);

    // Continuous contention from a fresh reset.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    last_k = 1;
    tick;
`ifdef MUL_ARB_RR_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    a0 = 8'd1; b0 = 8'd2; a1 = 8'd4; b1 = 8'd16;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      serve(0, 1'b0, k);
      chk("tie_winner", 16'(k), 16'(exp_seq[n]));
      chk("tie_result", 16'(result), (exp_seq[n] == 0) ? 16'h02 : 16'h40);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;
    tick;

    // Reset in the middle of CALC aborts without a done pulse.
    a1 = 8'd4; b1 = 8'd16; req1 = 1'b1;
    tick;
    chk("abort_gnt_pre", 16'(gnt), 16'b10);
    reset = 1'b1;
    tick;
    chk("abort_gnt", 16'(gnt), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_result", 16'(result), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    req1 = 1'b0;
    last_k = 1;
    tick;
    chk("abort_no_done", 16'(done), 16'd0);
    a0 = 8'd1; b0 = 8'd2; req0 = 1'b1;
    serve(0, 1'b1, k);
    chk("post_abort_result", 16'(result), 16'h02);

    // req1 raised while requester 0 is in CALC waits for IDLE.
    a0 = 8'd9; b0 = 8'd112; a1 = 8'd4; b1 = 8'd16; req0 = 1'b1;
    serve(2, 1'b1, k);
    chk("late_first", 16'(k), 16'd0);
    serve(0, 1'b1, k);
    chk("late_second", 16'(k), 16'd1);
    chk("late_result", 16'(result), 16'h40);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      if (!req0 && !req1) begin
        case ($urandom_range(1, 3))
          1: begin a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1; end
          2: begin a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1; end
          default: begin
            a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
            a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1;
          end
        endcase
      end else if ($urandom_range(0, 1) == 1) begin
        if (!req0) begin a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1; end
        if (!req1) begin a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1; end
      end
      drop = ($urandom_range(0, 3) != 0);
      serve(0, drop, k);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Shares the single combinational eight_bit_multiplier_module between two requesters (e.g. ALU and address-generation path).
- Arbitrates, latches the winner's operands and drives them into the only multiplier instance.
- Waits a configurable settle time, registers the 8-bit product and returns it with a one-cycle done pulse.
- Sits in Core between the requesting units and the multiplier datapath.

Parameters:
WAIT_CYCLES, 0, extra settle cycles in CALC before the product is captured (legal 0..7).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 request; held high with a0/b0 stable until done[0]
a0  input  8  requester 0 multiplicand
b0  input  8  requester 0 multiplier
req1  input  1  requester 1 request; same rules as req0
a1  input  8  requester 1 multiplicand
b1  input  8  requester 1 multiplier
gnt  output  2  one-hot grant; bit k = requester k owns the multiplier
done  output  2  one-hot, one-cycle pulse; result valid for requester k
result  output  8  registered product (low 8 bits of a*b, as produced by the multiplier)
busy  output  1  high in CALC and RESP

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous, active-high, named reset.
  - Reset values: state=IDLE, gnt=0, done=0, result=0, busy=0, op_a=op_b=0, cnt=0, last_gnt=1 (so req0 wins the first tie).
- Structure:
  - Exactly one eight_bit_multiplier_module instance.
  - Its a/b inputs are driven only from the internal op_a/op_b registers, never directly from a0/b0/a1/b1.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If req0 or req1 is high, select winner k, latch op_a<=a_k, op_b<=b_k, gnt<=onehot(k), last_gnt<=k, cnt<=WAIT_CYCLES, go to CALC.
  - Else stay in IDLE with gnt=0.
- CALC:
  - If cnt==0: result<=multiplier out, go to RESP.
  - Else cnt<=cnt-1.
  - CALC lasts WAIT_CYCLES+1 cycles.
- RESP:
  - done[k]=1 for exactly this one cycle; gnt held.
  - Next edge: gnt<=0, go to IDLE.
- Latency:
  - done[k] is asserted in cycle N+2+WAIT_CYCLES, where cycle N is the IDLE cycle in which req_k is first seen.
  - Throughput is one operation per WAIT_CYCLES+3 cycles.
- result holds its value until the next capture; it is not cleared on return to IDLE.
- Requester protocol:
  - A requester deasserts req at the same edge that ends the done cycle.
  - A req still high in IDLE is treated as a new request and is re-arbitrated.
- Requests that arrive during CALC/RESP are ignored until IDLE.
- Operand changes on a_k/b_k after the grant have no effect (operands are latched).
- Simultaneous req0 and req1 in IDLE: resolved by the arbitration policy (see Optional Feature).
- Reset asserted in any state aborts the operation: no done pulse, outputs return to reset values on the next edge.
- Arithmetic: result is the multiplier output unmodified; no overflow flag.

Optional Feature:
MUL_ARB_RR_EN
- Defined: round-robin arbitration. On a tie, grant the requester not equal to last_gnt. A lone requester always wins.
- Undefined: fixed priority; req0 always wins a tie. last_gnt is still maintained but does not affect arbitration.

Test Plan:
1. Reset, then req0=1, a0=1, b0=2, WAIT_CYCLES=0 -> gnt=01 from cycle N+1, done=01 pulse in cycle N+2 only, result=2, busy high for 2 cycles.
2. req1=1, a1=4, b1=16, WAIT_CYCLES=3 -> done=10 in cycle N+5, result=64. Changing a1 to 0 during CALC leaves result=64.
3. Overflow truncation: a0=64, b0=12 -> result=0x00. Then a0=9, b0=112 -> result=0xF0.
4. req0 and req1 both high continuously, operands 1*2 and 4*16 -> with MUL_ARB_RR_EN, grants alternate 01,10,01 and results alternate 2,64. Without it, the sequence is 01,01,01 and req1 starves.
5. Reset asserted during CALC of 4*16 -> no done pulse, gnt=0, result=0 next cycle; a subsequent req0 1*2 completes normally with result=2.
6. req1 raised while requester 0 is in CALC -> ignored until IDLE, then granted. done[1] arrives WAIT_CYCLES+2 cycles after IDLE is re-entered.
